// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider.
// Each channel runs a period counter; new settings are held in a shadow register and applied only at period boundaries.
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 28,
    parameter int DEF_DIV  = 50,
    parameter int DEF_HIGH = 25,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic [CHANNELS-1:0] Enable,
    input  logic                SyncIn,
    input  logic                CfgWe,
    input  logic [CH_W-1:0]     CfgCh,
    input  logic [WIDTH-1:0]    CfgDiv,
    input  logic [WIDTH-1:0]    CfgHigh,
    output logic [CHANNELS-1:0] ClkDiv,
    output logic [CHANNELS-1:0] Tick,
    output logic [CHANNELS-1:0] Pending
);

    localparam logic [WIDTH-1:0] L_DEF_DIV  = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] L_DEF_HIGH = WIDTH'(DEF_HIGH);

    // A period shorter than two cycles cannot hold both a high and a low phase.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_high;
        logic [WIDTH-1:0] r_sdiv;
        logic [WIDTH-1:0] r_shigh;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;
        logic             w_we;
        logic             w_wrap;
        logic             w_bound;
        logic             w_clk_nxt;

        // Out-of-range channel numbers never match any g, so such writes are dropped.
        assign w_we      = CfgWe & (CfgCh == CH_W'(g));
        assign w_wrap    = (r_cnt >= (r_div - WIDTH'(1)));
        assign w_bound   = ~Enable[g] | SyncIn | w_wrap;
        assign w_clk_nxt = Enable[g] & (r_cnt < r_high);

        // Per-channel counter, active/shadow settings and registered outputs.
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                r_cnt   <= '0;
                r_div   <= clamp_div(L_DEF_DIV);
                r_high  <= L_DEF_HIGH;
                r_sdiv  <= L_DEF_DIV;
                r_shigh <= L_DEF_HIGH;
                r_pend  <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_clk  <= w_clk_nxt;
                r_tick <= Enable[g] & ~SyncIn & w_wrap;

                if (w_bound) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end

                // The boundary consumes the shadow present before any same-cycle write.
                if (w_bound && r_pend) begin
                    r_div  <= clamp_div(r_sdiv);
                    r_high <= r_shigh;
                end else begin
                    r_div  <= r_div;
                    r_high <= r_high;
                end

                if (w_we) begin
                    r_sdiv  <= CfgDiv;
                    r_shigh <= CfgHigh;
                end else begin
                    r_sdiv  <= r_sdiv;
                    r_shigh <= r_shigh;
                end

                r_pend <= w_we | (r_pend & ~w_bound);
            end
        end

        assign ClkDiv[g]  = r_clk;
        assign Tick[g]    = r_tick;
        assign Pending[g] = r_pend;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: reference model on random traffic,
// directed corner sequences, and a hand-derived vector table on a small instance.
module tb_clk_div_multi;

    localparam int CH = 4;

    logic        Clk = 1'b0;
    logic        RstN;
    logic [3:0]  Enable;
    logic        SyncIn;
    logic        CfgWe;
    logic [1:0]  CfgCh;
    logic [27:0] CfgDiv;
    logic [27:0] CfgHigh;
    logic [3:0]  ClkDiv;
    logic [3:0]  Tick;
    logic [3:0]  Pending;

    logic [2:0]  s_en;
    logic        s_sync;
    logic        s_we;
    logic [1:0]  s_ch;
    logic [7:0]  s_div;
    logic [7:0]  s_high;
    logic [2:0]  s_clk;
    logic [2:0]  s_tick;
    logic [2:0]  s_pend;

    always #5 Clk = ~Clk;

    clk_div_multi u_dut (
        .Clk(Clk), .RstN(RstN), .Enable(Enable), .SyncIn(SyncIn),
        .CfgWe(CfgWe), .CfgCh(CfgCh), .CfgDiv(CfgDiv), .CfgHigh(CfgHigh),
        .ClkDiv(ClkDiv), .Tick(Tick), .Pending(Pending)
    );

    clk_div_multi #(.CHANNELS(3), .WIDTH(8), .DEF_DIV(4), .DEF_HIGH(2)) u_small (
        .Clk(Clk), .RstN(RstN), .Enable(s_en), .SyncIn(s_sync),
        .CfgWe(s_we), .CfgCh(s_ch), .CfgDiv(s_div), .CfgHigh(s_high),
        .ClkDiv(s_clk), .Tick(s_tick), .Pending(s_pend)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase within the current period plus active and shadow settings.
    int       m_p   [CH];
    int       m_per [CH];
    int       m_hi  [CH];
    int       m_sd  [CH];
    int       m_sh  [CH];
    bit       m_pend[CH];
    bit [3:0] m_clk;
    bit [3:0] m_tick;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_p[c] = 0; m_per[c] = 50; m_hi[c] = 25;
            m_sd[c] = 50; m_sh[c] = 25; m_pend[c] = 1'b0;
        end
        m_clk  = '0;
        m_tick = '0;
    endfunction

    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            bit last_cycle;
            bit restart;
            last_cycle = (m_p[c] + 1 >= m_per[c]);
            m_clk[c]   = Enable[c] && (m_p[c] < m_hi[c]);
            m_tick[c]  = Enable[c] && !SyncIn && last_cycle;
            restart    = !Enable[c] || SyncIn || last_cycle;
            if (restart) begin
                m_p[c] = 0;
                if (m_pend[c]) begin
                    m_per[c]  = (m_sd[c] < 2) ? 2 : m_sd[c];
                    m_hi[c]   = m_sh[c];
                    m_pend[c] = 1'b0;
                end
            end else begin
                m_p[c] = m_p[c] + 1;
            end
            if (CfgWe && int'(CfgCh) == c) begin
                m_sd[c]   = int'(CfgDiv);
                m_sh[c]   = int'(CfgHigh);
                m_pend[c] = 1'b1;
            end
        end
    endfunction

    task automatic compare_all();
        logic [3:0] pv;
        for (int c = 0; c < CH; c++) pv[c] = m_pend[c];
        check("model_clkdiv", 64'(ClkDiv), 64'(m_clk));
        check("model_tick", 64'(Tick), 64'(m_tick));
        check("model_pending", 64'(Pending), 64'(pv));
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic write_cfg(input int ch, input int d, input int h);
        CfgWe = 1'b1; CfgCh = 2'(ch); CfgDiv = 28'(d); CfgHigh = 28'(h);
        cyc();
        CfgWe = 1'b0;
    endtask

    task automatic wait_pend_clear(input int ch, input int max_cyc, output int n);
        n = 0;
        while (Pending[ch] && n < max_cyc) begin
            cyc();
            n++;
        end
        check("pending_clear_timeout", 64'(Pending[ch]), 64'd0);
    endtask

    typedef struct {
        logic [2:0] en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] dv;
        logic [7:0] hi;
        logic [2:0] e_clk;
        logic [2:0] e_tick;
        logic [2:0] e_pend;
    } vec_t;
    vec_t tbl[13];

    int n, first, highs, ticks, tog;
    logic prev;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b000, 3'b000};
        tbl[1]  = '{3'b001, 1'b1, 2'd3, 8'd5, 8'd1, 3'b001, 3'b000, 3'b000};
        tbl[2]  = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        tbl[3]  = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b001, 3'b000};
        tbl[4]  = '{3'b001, 1'b1, 2'd1, 8'd3, 8'd1, 3'b001, 3'b000, 3'b010};
        tbl[5]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b000, 3'b010};
        tbl[6]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b010};
        tbl[7]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b001, 3'b010};
        tbl[8]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b010, 3'b000};
        tbl[9]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b000, 3'b000};
        tbl[10] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        tbl[11] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b011, 3'b000};
        tbl[12] = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b000, 3'b000};

        RstN = 1'b0; Enable = '0; SyncIn = 1'b0; CfgWe = 1'b0; CfgCh = '0; CfgDiv = '0; CfgHigh = '0;
        s_en = '0; s_sync = 1'b0; s_we = 1'b0; s_ch = '0; s_div = '0; s_high = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        check("reset_clkdiv", 64'(ClkDiv), 64'd0);
        check("reset_tick", 64'(Tick), 64'd0);
        check("reset_pending", 64'(Pending), 64'd0);
        check("reset_small_out", 64'({s_clk, s_tick, s_pend}), 64'd0);

        // Defaults: period 50, high 25, first tick 50 cycles after enable.
        Enable = 4'b0011;
        first = 0; highs = 0; ticks = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (Tick[0]) begin
                ticks++;
                if (first == 0) first = i;
            end
            if (i <= 50 && ClkDiv[0]) highs++;
        end
        check("default_first_tick", 64'(first), 64'd50);
        check("default_high_cycles", 64'(highs), 64'd25);
        check("default_tick_count", 64'(ticks), 64'd2);

        // Mid-period reconfiguration of ch1 waits for the old period to finish.
        repeat (20) cyc();
        write_cfg(1, 10, 3);
        check("ch1_pending_set", 64'(Pending[1]), 64'd1);
        wait_pend_clear(1, 60, n);
        check("ch1_pending_cycles", 64'(n), 64'd29);
        check("ch1_tick_at_apply", 64'(Tick[1]), 64'd1);
        highs = 0; ticks = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            highs += int'(ClkDiv[1]);
            ticks += int'(Tick[1]);
        end
        check("ch1_new_highs", 64'(highs), 64'd9);
        check("ch1_new_ticks", 64'(ticks), 64'd3);

        // Divisors 0 and 1 clamp to 2.
        Enable = 4'b0111;
        for (int k = 0; k < 2; k++) begin
            write_cfg(2, k, 1);
            wait_pend_clear(2, 60, n);
            prev = ClkDiv[2]; tog = 0; ticks = 0;
            for (int i = 0; i < 8; i++) begin
                cyc();
                if (ClkDiv[2] != prev) tog++;
                prev = ClkDiv[2];
                ticks += int'(Tick[2]);
            end
            check("ch2_small_div_toggles", 64'(tog), 64'd8);
            check("ch2_small_div_ticks", 64'(ticks), 64'd4);
        end
        write_cfg(2, 5, 0);
        wait_pend_clear(2, 60, n);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            highs += int'(ClkDiv[2]);
        end
        check("ch2_high0_stuck_low", 64'(highs), 64'd0);
        write_cfg(2, 8, 99);
        wait_pend_clear(2, 60, n);
        highs = 0; ticks = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            highs += int'(ClkDiv[2]);
            ticks += int'(Tick[2]);
        end
        check("ch2_high_ge_div_stuck_high", 64'(highs), 64'd16);
        check("ch2_high_ge_div_ticks", 64'(ticks), 64'd2);

        // Two writes before the boundary: only the last one takes effect.
        Enable = 4'b1111;
        repeat (2) cyc();
        write_cfg(3, 6, 3);
        write_cfg(3, 12, 3);
        wait_pend_clear(3, 60, n);
        highs = 0; ticks = 0;
        for (int i = 0; i < 36; i++) begin
            cyc();
            highs += int'(ClkDiv[3]);
            ticks += int'(Tick[3]);
        end
        check("ch3_last_write_ticks", 64'(ticks), 64'd3);
        check("ch3_last_write_highs", 64'(highs), 64'd9);

        // Phase alignment with SyncIn after offsetting ch1.
        write_cfg(0, 7, 3);
        write_cfg(1, 7, 3);
        wait_pend_clear(0, 60, n);
        wait_pend_clear(1, 60, n);
        Enable = 4'b1101;
        repeat (3) cyc();
        Enable = 4'b1111;
        repeat (5) cyc();
        SyncIn = 1'b1;
        cyc();
        SyncIn = 1'b0;
        check("sync_no_tick", 64'(Tick), 64'd0);
        first = 0;
        for (int i = 1; i <= 21; i++) begin
            cyc();
            check("sync_aligned_clkdiv", 64'(ClkDiv[0]), 64'(ClkDiv[1]));
            if (Tick[0] && first == 0) first = i;
        end
        check("sync_first_tick", 64'(first), 64'd7);

        // Asynchronous reset while a config is pending.
        write_cfg(0, 9, 2);
        check("pend_before_reset", 64'(Pending[0]), 64'd1);
        #2;
        RstN = 1'b0;
        #1;
        check("async_reset_clkdiv", 64'(ClkDiv), 64'd0);
        check("async_reset_tick", 64'(Tick), 64'd0);
        check("async_reset_pending", 64'(Pending), 64'd0);
        model_reset();
        Enable = 4'b0001;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        first = 0;
        for (int i = 1; i <= 50; i++) begin
            cyc();
            if (Tick[0] && first == 0) first = i;
        end
        check("post_reset_default_period", 64'(first), 64'd50);

        // Disable and re-enable mid-period restarts from a zero count.
        repeat (13) cyc();
        Enable = 4'b0000;
        cyc();
        check("disable_clkdiv_low", 64'(ClkDiv[0]), 64'd0);
        Enable = 4'b0001;
        first = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc();
            if (i == 1) check("reenable_clkdiv_high", 64'(ClkDiv[0]), 64'd1);
            if (Tick[0] && first == 0) first = i;
        end
        check("reenable_first_tick", 64'(first), 64'd50);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) Enable[$urandom_range(0, 3)] ^= 1'b1;
            SyncIn = ($urandom_range(0, 99) == 0);
            CfgWe  = ($urandom_range(0, 7) == 0);
            CfgCh  = 2'($urandom_range(0, 3));
            CfgDiv = 28'($urandom_range(0, 20));
            CfgHigh = 28'($urandom_range(0, 22));
            cyc();
        end
        SyncIn = 1'b0; CfgWe = 1'b0;

        // Hand-derived vectors on the 3-channel instance, including a write to channel 3.
        for (int r = 0; r < 13; r++) begin
            s_en = tbl[r].en; s_we = tbl[r].we; s_ch = tbl[r].ch;
            s_div = tbl[r].dv; s_high = tbl[r].hi;
            @(posedge Clk);
            #1;
            check($sformatf("tbl%0d_clkdiv", r), 64'(s_clk), 64'(tbl[r].e_clk));
            check($sformatf("tbl%0d_tick", r), 64'(s_tick), 64'(tbl[r].e_tick));
            check($sformatf("tbl%0d_pending", r), 64'(s_pend), 64'(tbl[r].e_pend));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
